// File: rtl/mul_share_sequencer.sv
// mul_share_sequencer
//   Shares one radix-4 shift-add multiplier between two requesters.
//   A round-robin arbiter picks a requester in IDLE and latches its operands.
//   RUN retires one 2-bit multiplier digit per cycle. DONE publishes the product.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a request; arbitrates and captures operands
//   RUN   | one radix-4 digit per cycle, SIZE/2 cycles; iAbort cancels
//   DONE  | loads oResult/oOwner and pulses oValid, then back to IDLE
//
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   iReq0/iA0/iB0       requester 0 request and operands
//   iReq1/iA1/iB1       requester 1 request and operands
//   iAbort              cancels a product in RUN (ignored in IDLE and DONE)
//   oGnt0/oGnt1         one-cycle pulse when that requester's operands are captured
//   oBusy               high whenever the state is not IDLE
//   oValid              one-cycle pulse with a new oResult/oOwner
//   oOwner, oResult     owner index and unsigned 2*SIZE-bit product; held until next DONE
module mul_share_sequencer #(
    parameter int SIZE = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iReq0,
    input  logic [SIZE-1:0]     iA0,
    input  logic [SIZE-1:0]     iB0,
    input  logic                iReq1,
    input  logic [SIZE-1:0]     iA1,
    input  logic [SIZE-1:0]     iB1,
    input  logic                iAbort,
    output logic                oGnt0,
    output logic                oGnt1,
    output logic                oBusy,
    output logic                oValid,
    output logic                oOwner,
    output logic [2*SIZE-1:0]   oResult
);

    localparam int DIGITS = SIZE / 2;
    localparam int CW     = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic                last;      // index of the requester served most recently
    logic                owner;
    logic [2*SIZE-1:0]   acc;
    logic [2*SIZE-1:0]   a_sh;      // multiplicand, pre-shifted by 2k for digit k
    logic [SIZE-1:0]     b_sh;      // multiplier, current digit in bits [1:0]
    logic [CW-1:0]       cnt;

    logic                any_req;
    logic                win;
    logic [2*SIZE-1:0]   pp;

    always_comb begin
        any_req = iReq0 | iReq1;
        // A lone request wins outright; on a tie the side not served last wins.
        win = (iReq0 & iReq1) ? ~last : iReq1;
    end

    // a_sh already carries the 2k shift, so the partial product needs no
    // extra shifter. 3*A<<(SIZE-2) still fits in 2*SIZE bits.
    always_comb begin
        pp = '0;
        case (b_sh[1:0])
            2'b00:   pp = '0;
            2'b01:   pp = a_sh;
            2'b10:   pp = a_sh << 1;
            2'b11:   pp = (a_sh << 1) + a_sh;
            default: pp = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            oGnt0   <= 1'b0;
            oGnt1   <= 1'b0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
            oOwner  <= 1'b0;
            oResult <= '0;
        end else begin
            oGnt0  <= 1'b0;
            oGnt1  <= 1'b0;
            oValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= win;
                        last  <= win;
                        a_sh  <= {{SIZE{1'b0}}, (win ? iA1 : iA0)};
                        b_sh  <= win ? iB1 : iB0;
                        acc   <= '0;
                        cnt   <= '0;
                        oGnt0 <= ~win;
                        oGnt1 <= win;
                        oBusy <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (iAbort) begin
                        oBusy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc  <= acc + pp;
                        a_sh <= a_sh << 2;
                        b_sh <= b_sh >> 2;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_DIGIT)
                            state <= DONE;
                    end
                end
                DONE: begin
                    oResult <= acc;
                    oOwner  <= owner;
                    oValid  <= 1'b1;
                    oBusy   <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_sequencer.sv
// tb_mul_share_sequencer
//   Directed bench for mul_share_sequencer with SIZE=16.
//   A transaction-level model tracks where each product is in its timeline:
//   capture, SIZE/2 digit cycles, a DONE cycle, then publish. It computes each
//   product with a plain multiply. A negedge process compares every output
//   against that model. The scenarios also check hand-computed literals.
module tb_mul_share_sequencer;

    localparam int SIZE = 16;
    localparam int DIG  = SIZE / 2;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              iReq0 = 1'b0, iReq1 = 1'b0, iAbort = 1'b0;
    logic [SIZE-1:0]   iA0 = '0, iB0 = '0, iA1 = '0, iB1 = '0;
    logic              oGnt0, oGnt1, oBusy, oValid, oOwner;
    logic [2*SIZE-1:0] oResult;

    int n_checks = 0;
    int n_errors = 0;

    mul_share_sequencer #(.SIZE(SIZE)) dut (
        .Clock(Clock), .Reset(Reset),
        .iReq0(iReq0), .iA0(iA0), .iB0(iB0),
        .iReq1(iReq1), .iA1(iA1), .iB1(iB1),
        .iAbort(iAbort),
        .oGnt0(oGnt0), .oGnt1(oGnt1), .oBusy(oBusy), .oValid(oValid),
        .oOwner(oOwner), .oResult(oResult)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts edges since capture (0 = idle).
    // 1..DIG are digit cycles, DIG+1 is the publish cycle.
    int                m_t;
    bit                m_last;
    bit                m_own;
    logic [2*SIZE-1:0] m_prod;
    bit                e_g0, e_g1, e_valid, e_own, e_busy;
    logic [2*SIZE-1:0] e_res;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_t = 0; m_last = 1'b1; m_own = 1'b0; m_prod = '0;
            e_g0 = 0; e_g1 = 0; e_valid = 0; e_own = 0; e_busy = 0; e_res = '0;
        end else begin
            e_g0 = 0; e_g1 = 0; e_valid = 0;
            if (m_t == 0) begin
                if (iReq0 || iReq1) begin
                    bit w;
                    w = (iReq0 && iReq1) ? !m_last : iReq1;
                    m_last = w;
                    m_own  = w;
                    m_prod = w ? ({16'h0, iA1} * {16'h0, iB1}) : ({16'h0, iA0} * {16'h0, iB0});
                    e_g0 = !w; e_g1 = w;
                    m_t = 1;
                end
            end else if (m_t <= DIG) begin
                if (iAbort) m_t = 0;
                else m_t++;
            end else begin
                e_valid = 1; e_res = m_prod; e_own = m_own;
                m_t = 0;
            end
            e_busy = (m_t != 0);
        end
    end

    always @(negedge Clock) begin
        check("gnt0", {63'h0, oGnt0}, {63'h0, e_g0});
        check("gnt1", {63'h0, oGnt1}, {63'h0, e_g1});
        check("busy", {63'h0, oBusy}, {63'h0, e_busy});
        check("valid", {63'h0, oValid}, {63'h0, e_valid});
        check("owner", {63'h0, oOwner}, {63'h0, e_own});
        check("result", {32'h0, oResult}, {32'h0, e_res});
    end

    // Waits for either grant. Returns at the negedge where it is visible.
    task automatic wait_gnt(output bit which, output bit ok);
        ok = 0; which = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (oGnt0 || oGnt1) begin
                ok = 1; which = oGnt1;
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL gnt_timeout: got no grant expected a grant at %0t", $time);
        end
    endtask

    // Latency is counted in cycles after the capture edge.
    // The grant cycle is cycle 1.
    task automatic wait_valid(output logic [31:0] res, output bit own, output int lat);
        bit ok;
        ok = 0; lat = 1; res = '0; own = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            lat++;
            if (oValid) begin
                ok = 1; res = oResult; own = oOwner;
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL valid_timeout: got no oValid expected oValid at %0t", $time);
        end
    endtask

    task automatic start_req(input bit r, input logic [15:0] a, input logic [15:0] b);
        if (r) begin iReq1 = 1; iA1 = a; iB1 = b; end
        else   begin iReq0 = 1; iA0 = a; iB0 = b; end
    endtask

    task automatic drop_req(input bit r);
        if (r) iReq1 = 0; else iReq0 = 0;
    endtask

    task automatic run_one(input string tag, input bit r, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp_res);
        bit which, ok, own;
        logic [31:0] res;
        int lat;
        @(negedge Clock); #1;
        start_req(r, a, b);
        wait_gnt(which, ok);
        check({tag, "_gnt_idx"}, {63'h0, which}, {63'h0, r});
        #1 drop_req(r);
        wait_valid(res, own, lat);
        check({tag, "_res"}, {32'h0, res}, {32'h0, exp_res});
        check({tag, "_own"}, {63'h0, own}, {63'h0, r});
        check({tag, "_lat"}, 64'(lat), 64'd10);
    endtask

    task automatic pulse_reset();
        @(negedge Clock); #1 Reset = 1;
        @(negedge Clock); #1 Reset = 0;
    endtask

    initial begin
        bit which, ok, own;
        logic [31:0] res;
        int lat;

        repeat (2) @(negedge Clock);
        check("rst_result", {32'h0, oResult}, 64'h0);
        check("rst_busy", {63'h0, oBusy}, 64'h0);
        #1 Reset = 0;

        run_one("s3x5", 0, 16'd3, 16'd5, 32'd15);
        run_one("ffff", 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_one("d11", 1, 16'h0101, 16'h0003, 32'h00000303);

        // Simultaneous requests straight after reset
        pulse_reset();
        @(negedge Clock); #1;
        start_req(0, 16'd7, 16'd3);
        start_req(1, 16'h1234, 16'h0010);
        wait_gnt(which, ok);
        check("rr1_idx", {63'h0, which}, 64'd0);
        #1 drop_req(0);
        wait_valid(res, own, lat);
        check("rr1_res", {32'h0, res}, 64'd21);
        check("rr1_own", {63'h0, own}, 64'd0);
        wait_gnt(which, ok);
        check("rr2_idx", {63'h0, which}, 64'd1);
        #1 drop_req(1);
        wait_valid(res, own, lat);
        check("rr2_res", {32'h0, res}, 64'h12340);
        check("rr2_own", {63'h0, own}, 64'd1);
        @(negedge Clock); #1;
        start_req(0, 16'd2, 16'd3);
        start_req(1, 16'd4, 16'd5);
        wait_gnt(which, ok);
        check("rr3_idx", {63'h0, which}, 64'd0);
        #1 drop_req(0);
        wait_valid(res, own, lat);
        check("rr3_res", {32'h0, res}, 64'd6);
        wait_gnt(which, ok);
        check("rr4_idx", {63'h0, which}, 64'd1);
        #1 drop_req(1);
        wait_valid(res, own, lat);
        check("rr4_res", {32'h0, res}, 64'd20);
        check("rr4_own", {63'h0, own}, 64'd1);

        // Abort sampled at the edge that ends the 4th digit cycle
        @(negedge Clock); #1 start_req(0, 16'd9, 16'd9);
        wait_gnt(which, ok);
        #1 drop_req(0);
        repeat (3) @(negedge Clock);
        #1 iAbort = 1;
        @(negedge Clock);
        check("abort_busy", {63'h0, oBusy}, 64'd0);
        check("abort_valid", {63'h0, oValid}, 64'd0);
        check("abort_res", {32'h0, oResult}, 64'd20);
        #1 iAbort = 0;
        repeat (12) @(negedge Clock);
        check("abort_res_held", {32'h0, oResult}, 64'd20);
        run_one("post_abort", 1, 16'd6, 16'd7, 32'd42);

        // Asynchronous reset in the middle of RUN
        @(negedge Clock); #1 start_req(0, 16'd100, 16'd100);
        wait_gnt(which, ok);
        #1 drop_req(0);
        repeat (3) @(negedge Clock);
        #2 Reset = 1;
        #1;
        check("arst_outs", {32'h0, oResult, oGnt0, oGnt1, oBusy, oValid, oOwner},
              64'h0);
        @(negedge Clock); #1 Reset = 0;
        repeat (12) @(negedge Clock);
        check("arst_no_result", {32'h0, oResult}, 64'h0);
        run_one("post_rst", 0, 16'd2, 16'd2, 32'd4);

        repeat (3) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
